// File: rtl/mrd_sched_pkg.sv
// Shared types and helpers for the N-bank mixed-radix DFT frame scheduler.
package mrd_sched_pkg;

    localparam int unsigned PTS_W_DEF = 12;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FILL   = 3'd1,
        ST_READY  = 3'd2,
        ST_CALC   = 3'd3,
        ST_OUTRDY = 3'd4,
        ST_OUT    = 3'd5
    } bank_state_e;

    function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned nbank);
        return (ptr + 32'd1 >= nbank) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/mrd_bank_slot.sv
// One memory bank's lifecycle: Fill -> Ready -> Calc -> OutReady -> Out -> Idle,
// plus the frame length/IDFT flag captured on the sop beat and the fill beat count.
module mrd_bank_slot
    import mrd_sched_pkg::*;
#(
    parameter int unsigned PTS_W = PTS_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fill_fire,
    input  logic             sop,
    input  logic             eop,
    input  logic [PTS_W-1:0] dftpts_in,
    input  logic             inverse_in,
    input  logic             calc_issue,
    input  logic             calc_fin,
    input  logic             out_issue,
    input  logic             out_fin,
    output bank_state_e      state,
    output bank_state_e      state_nxt,
    output logic [PTS_W-1:0] dftpts,
    output logic             inverse,
    output logic             fill_err
);

    localparam logic [PTS_W:0] CNT_ONE = {{PTS_W{1'b0}}, 1'b1};

    logic [PTS_W:0]   cnt;
    logic [PTS_W:0]   cnt_nxt;
    logic [PTS_W-1:0] pts_nxt;
    logic             inv_nxt;
    logic             take;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pts_nxt   = dftpts;
        inv_nxt   = inverse;
        fill_err  = 1'b0;
        take      = 1'b0;
        case (state)
            ST_IDLE, ST_FILL: begin
                if (fill_fire) begin
                    // sop always (re)starts a frame; a sop seen mid-fill is a restart error
                    if (sop) begin
                        take     = 1'b1;
                        pts_nxt  = dftpts_in;
                        inv_nxt  = inverse_in;
                        cnt_nxt  = CNT_ONE;
                        fill_err = (state == ST_FILL);
                    end else if (state == ST_FILL) begin
                        take    = 1'b1;
                        cnt_nxt = cnt + CNT_ONE;
                    end else begin
                        fill_err = 1'b1;
                    end
                    if (take) begin
                        state_nxt = eop ? ST_READY : ST_FILL;
                        if (eop && (cnt_nxt != {1'b0, pts_nxt})) begin
                            fill_err = 1'b1;
                        end
                    end
                end
            end
            ST_READY:  if (calc_issue) state_nxt = ST_CALC;
            ST_CALC:   if (calc_fin)   state_nxt = ST_OUTRDY;
            ST_OUTRDY: if (out_issue)  state_nxt = ST_OUT;
            ST_OUT:    if (out_fin)    state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            dftpts  <= '0;
            inverse <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            dftpts  <= pts_nxt;
            inverse <= inv_nxt;
        end
    end

endmodule

// File: rtl/mrd_bank_sched.sv
// Round-robin N-bank frame scheduler: owns the fill/calc/drain pointers, issues
// engine and drain start pulses in frame order, and flags framing/protocol errors.
module mrd_bank_sched
    import mrd_sched_pkg::*;
#(
    parameter int unsigned NBANK = 2,
    parameter int unsigned BW    = (NBANK > 2) ? $clog2(NBANK) : 1,
    parameter int unsigned PTS_W = PTS_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sink_valid,
    output logic             sink_ready,
    input  logic             sink_sop,
    input  logic             sink_eop,
    input  logic [PTS_W-1:0] sink_dftpts,
    input  logic             sink_inverse,
    output logic [BW-1:0]    in_bank,
    output logic             calc_start,
    output logic [BW-1:0]    calc_bank,
    output logic [PTS_W-1:0] calc_dftpts,
    output logic             calc_inverse,
    input  logic             calc_done,
    output logic             out_start,
    output logic [BW-1:0]    out_bank,
    output logic [PTS_W-1:0] out_dftpts,
    input  logic             out_done,
    output logic             frame_err,
    output logic             proto_err,
    output logic             busy
);

    bank_state_e      st     [NBANK];
    bank_state_e      st_nxt [NBANK];
    logic [PTS_W-1:0] bk_pts [NBANK];
    logic             bk_inv [NBANK];
    logic [NBANK-1:0] bk_err;

    logic [BW-1:0] wr_ptr;
    logic [BW-1:0] calc_ptr;
    logic [BW-1:0] rd_ptr;

    logic wr_ok;
    logic fire;
    logic complete;
    logic any_calc;
    logic any_out;
    logic calc_issue;
    logic calc_fin;
    logic out_issue;
    logic out_fin;
    logic busy_nxt;

    assign wr_ok      = (st[wr_ptr] == ST_IDLE) || (st[wr_ptr] == ST_FILL);
    assign sink_ready = !rst && wr_ok;
    assign fire       = sink_valid && sink_ready;
    assign complete   = fire && sink_eop && (sink_sop || (st[wr_ptr] == ST_FILL));
    assign in_bank    = wr_ptr;

    always_comb begin
        any_calc = 1'b0;
        any_out  = 1'b0;
        for (int unsigned i = 0; i < NBANK; i++) begin
            if (st[i] == ST_CALC) any_calc = 1'b1;
            if (st[i] == ST_OUT)  any_out  = 1'b1;
        end
    end

    always_comb begin
        busy_nxt = 1'b0;
        for (int unsigned i = 0; i < NBANK; i++) begin
            if (st_nxt[i] != ST_IDLE) busy_nxt = 1'b1;
        end
    end

    // Issue only while no bank occupies the stage, so a completing bank and the
    // next issue never coincide: the next start follows one cycle after exit.
    assign calc_issue = !any_calc && (st[calc_ptr] == ST_READY);
    assign calc_fin   = calc_done && (st[calc_ptr] == ST_CALC);
    assign out_issue  = !any_out && (st[rd_ptr] == ST_OUTRDY);
    assign out_fin    = out_done && (st[rd_ptr] == ST_OUT);

    for (genvar g = 0; g < NBANK; g++) begin : g_bank
        mrd_bank_slot #(
            .PTS_W (PTS_W)
        ) u_slot (
            .clk        (clk),
            .rst        (rst),
            .fill_fire  (fire && (wr_ptr == BW'(g))),
            .sop        (sink_sop),
            .eop        (sink_eop),
            .dftpts_in  (sink_dftpts),
            .inverse_in (sink_inverse),
            .calc_issue (calc_issue && (calc_ptr == BW'(g))),
            .calc_fin   (calc_fin && (calc_ptr == BW'(g))),
            .out_issue  (out_issue && (rd_ptr == BW'(g))),
            .out_fin    (out_fin && (rd_ptr == BW'(g))),
            .state      (st[g]),
            .state_nxt  (st_nxt[g]),
            .dftpts     (bk_pts[g]),
            .inverse    (bk_inv[g]),
            .fill_err   (bk_err[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            calc_ptr     <= '0;
            rd_ptr       <= '0;
            calc_start   <= 1'b0;
            calc_bank    <= '0;
            calc_dftpts  <= '0;
            calc_inverse <= 1'b0;
            out_start    <= 1'b0;
            out_bank     <= '0;
            out_dftpts   <= '0;
            frame_err    <= 1'b0;
            proto_err    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            if (complete) wr_ptr   <= BW'(next_ptr(32'(wr_ptr), NBANK));
            if (calc_fin) calc_ptr <= BW'(next_ptr(32'(calc_ptr), NBANK));
            if (out_fin)  rd_ptr   <= BW'(next_ptr(32'(rd_ptr), NBANK));
            calc_start <= calc_issue;
            if (calc_issue) begin
                calc_bank    <= calc_ptr;
                calc_dftpts  <= bk_pts[calc_ptr];
                calc_inverse <= bk_inv[calc_ptr];
            end
            out_start <= out_issue;
            if (out_issue) begin
                out_bank   <= rd_ptr;
                out_dftpts <= bk_pts[rd_ptr];
            end
            frame_err <= |bk_err;
            proto_err <= (calc_done && !calc_fin) || (out_done && !out_fin);
            busy      <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_mrd_bank_sched.sv
// Directed bench for mrd_bank_sched: a 2-bank and a 4-bank instance share one stimulus stream.
module tb_mrd_bank_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sink_valid = 1'b0;
    logic        sink_sop = 1'b0;
    logic        sink_eop = 1'b0;
    logic [11:0] sink_dftpts = '0;
    logic        sink_inverse = 1'b0;
    logic        calc_done = 1'b0;
    logic        out_done = 1'b0;

    logic        r2, cs2, ci2, os2, fe2, pe2, bz2;
    logic        ib2, cb2, ob2;
    logic [11:0] cp2, op2;
    logic        r4, cs4, ci4, os4, fe4, pe4, bz4;
    logic [1:0]  ib4, cb4, ob4;
    logic [11:0] cp4, op4;

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    mrd_bank_sched #(.NBANK(2)) dut2 (
        .clk(clk), .rst(rst), .sink_valid(sink_valid), .sink_ready(r2),
        .sink_sop(sink_sop), .sink_eop(sink_eop), .sink_dftpts(sink_dftpts),
        .sink_inverse(sink_inverse), .in_bank(ib2), .calc_start(cs2),
        .calc_bank(cb2), .calc_dftpts(cp2), .calc_inverse(ci2), .calc_done(calc_done),
        .out_start(os2), .out_bank(ob2), .out_dftpts(op2), .out_done(out_done),
        .frame_err(fe2), .proto_err(pe2), .busy(bz2)
    );

    mrd_bank_sched #(.NBANK(4)) dut4 (
        .clk(clk), .rst(rst), .sink_valid(sink_valid), .sink_ready(r4),
        .sink_sop(sink_sop), .sink_eop(sink_eop), .sink_dftpts(sink_dftpts),
        .sink_inverse(sink_inverse), .in_bank(ib4), .calc_start(cs4),
        .calc_bank(cb4), .calc_dftpts(cp4), .calc_inverse(ci4), .calc_done(calc_done),
        .out_start(os4), .out_bank(ob4), .out_dftpts(op4), .out_done(out_done),
        .frame_err(fe4), .proto_err(pe4), .busy(bz4)
    );

    logic [1:0]  qb[$];
    logic [11:0] qp[$];
    bit          mon4 = 1'b0;

    always @(negedge clk) begin
        if (mon4 && cs4) begin
            qb.push_back(cb4);
            qp.push_back(cp4);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
        calc_done = 1'b0; out_done = 1'b0;
        #1;
        chk("ready in rst 2", r2, 0);
        chk("ready in rst 4", r4, 0);
        tick();
        chk("rst busy 2", bz2, 0);
        chk("rst in_bank 2", ib2, 0);
        chk("rst calc_start 2", cs2, 0);
        chk("rst calc_dftpts 2", cp2, 0);
        chk("rst frame_err 2", fe2, 0);
        chk("rst busy 4", bz4, 0);
        chk("rst in_bank 4", ib4, 0);
        rst = 1'b0;
        #1;
        chk("ready after rst 2", r2, 1);
        chk("ready after rst 4", r4, 1);
    endtask

    task automatic send_frame(input logic [11:0] pts, input int nbeats, input logic inv);
        for (int b = 0; b < nbeats; b++) begin
            sink_valid = 1'b1;
            sink_sop = (b == 0);
            sink_eop = (b == nbeats - 1);
            sink_dftpts = pts;
            sink_inverse = inv;
            tick();
        end
        sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
    endtask

    // Full single-frame pass through both instances starting from a freshly reset state.
    task automatic do_frame(input logic [11:0] pts, input int nbeats, input logic inv, input logic err);
        send_frame(pts, nbeats, inv);
        chk("eop frame_err 2", fe2, err);
        chk("eop frame_err 4", fe4, err);
        chk("eop calc_start early 2", cs2, 0);
        chk("eop busy 2", bz2, 1);
        tick();
        chk("calc_start 2", cs2, 1);
        chk("calc_bank 2", cb2, 0);
        chk("calc_dftpts 2", cp2, pts);
        chk("calc_inverse 2", ci2, inv);
        chk("calc_start 4", cs4, 1);
        chk("calc_dftpts 4", cp4, pts);
        chk("calc_inverse 4", ci4, inv);
        chk("frame_err cleared 2", fe2, 0);
        calc_done = 1'b1;
        tick();
        calc_done = 1'b0;
        chk("calc_start pulse 2", cs2, 0);
        chk("calc_done proto 2", pe2, 0);
        tick();
        chk("out_start 2", os2, 1);
        chk("out_bank 2", ob2, 0);
        chk("out_dftpts 2", op2, pts);
        chk("out_start 4", os4, 1);
        chk("out_dftpts 4", op4, pts);
        out_done = 1'b1;
        tick();
        out_done = 1'b0;
        chk("done busy 2", bz2, 0);
        chk("done busy 4", bz4, 0);
        chk("done in_bank 2", ib2, 1);
        chk("done in_bank 4", ib4, 1);
        chk("done proto 2", pe2, 0);
        chk("out_start pulse 2", os2, 0);
    endtask

    typedef struct {
        logic [11:0] pts;
        int          nbeats;
        logic        inv;
        logic        err;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{12'd12, 12, 1'b0, 1'b0};
        vecs[1] = '{12'd12, 11, 1'b0, 1'b1};
        vecs[2] = '{12'd24, 24, 1'b1, 1'b0};
        vecs[3] = '{12'd5,  5,  1'b0, 1'b0};
        vecs[4] = '{12'd1,  1,  1'b1, 1'b0};
        vecs[5] = '{12'd3,  4,  1'b0, 1'b1};
        vecs[6] = '{12'd8,  1,  1'b1, 1'b1};

        tick();
        for (int v = 0; v < 7; v++) begin
            do_reset();
            do_frame(vecs[v].pts, vecs[v].nbeats, vecs[v].inv, vecs[v].err);
        end

        // Two-bank back-pressure: third frame waits for bank 0 to drain.
        do_reset();
        send_frame(12'd12, 12, 1'b0);
        send_frame(12'd12, 12, 1'b0);
        chk("bp ready 2", r2, 0);
        chk("bp in_bank 2", ib2, 0);
        sink_valid = 1'b1; sink_sop = 1'b1; sink_eop = 1'b0; sink_dftpts = 12'd12;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp hold ready 2", r2, 0);
        end
        calc_done = 1'b1;
        tick();
        calc_done = 1'b0;
        for (int i = 0; i < 10 && !os2; i++) tick();
        chk("bp out_start 2", os2, 1);
        chk("bp out_bank 2", ob2, 0);
        out_done = 1'b1;
        tick();
        out_done = 1'b0;
        chk("bp release ready 2", r2, 1);
        chk("bp release in_bank 2", ib2, 0);
        tick();
        for (int b = 1; b < 12; b++) begin
            sink_sop = 1'b0;
            sink_eop = (b == 11);
            tick();
        end
        sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
        chk("bp frame2 in_bank 2", ib2, 1);
        chk("bp frame2 frame_err 2", fe2, 0);
        calc_done = 1'b1;
        tick();
        calc_done = 1'b0;
        for (int i = 0; i < 10 && !cs2; i++) tick();
        chk("bp frame2 calc_start 2", cs2, 1);
        chk("bp frame2 calc_bank 2", cb2, 0);
        chk("bp frame2 calc_dftpts 2", cp2, 12);

        // Four-bank ordering with growing frame lengths.
        do_reset();
        qb.delete();
        qp.delete();
        mon4 = 1'b1;
        for (int f = 0; f < 4; f++) send_frame(12'(12 * (f + 1)), 12 * (f + 1), 1'b0);
        chk("nb4 in_bank wrap", ib4, 0);
        chk("nb4 all busy ready", r4, 0);
        for (int f = 0; f < 4; f++) begin
            calc_done = 1'b1;
            tick();
            calc_done = 1'b0;
            tick();
            tick();
            chk("nb4 proto", pe4, 0);
        end
        mon4 = 1'b0;
        chk("nb4 issue count", qb.size(), 4);
        for (int k = 0; k < 4 && k < qb.size(); k++) begin
            chk("nb4 calc_bank", qb[k], k);
            chk("nb4 calc_dftpts", qp[k], 12 * (k + 1));
        end

        // Beat without sop on an idle bank, then a sop restart mid-fill.
        do_reset();
        sink_valid = 1'b1; sink_sop = 1'b0; sink_eop = 1'b0; sink_dftpts = 12'd12;
        tick();
        sink_valid = 1'b0;
        chk("stray frame_err 2", fe2, 1);
        chk("stray frame_err 4", fe4, 1);
        chk("stray busy 2", bz2, 0);
        tick();
        chk("stray pulse 2", fe2, 0);
        for (int b = 0; b < 4; b++) begin
            sink_valid = 1'b1;
            sink_sop = (b == 0) || (b == 3);
            tick();
        end
        sink_valid = 1'b0; sink_sop = 1'b0;
        chk("restart frame_err 2", fe2, 1);
        chk("restart busy 2", bz2, 1);

        // Completion pulses with nothing to complete.
        do_reset();
        calc_done = 1'b1;
        tick();
        calc_done = 1'b0;
        chk("stray calc_done proto 2", pe2, 1);
        chk("stray calc_done busy 2", bz2, 0);
        tick();
        chk("proto pulse 2", pe2, 0);
        out_done = 1'b1;
        tick();
        out_done = 1'b0;
        chk("stray out_done proto 4", pe4, 1);

        // Reset in the middle of a fill.
        do_reset();
        for (int b = 0; b < 5; b++) begin
            sink_valid = 1'b1;
            sink_sop = (b == 0);
            sink_dftpts = 12'd12;
            tick();
        end
        chk("midfill busy before rst 2", bz2, 1);
        rst = 1'b1;
        sink_valid = 1'b0; sink_sop = 1'b0;
        #1;
        chk("midfill rst busy 2", bz2, 0);
        chk("midfill rst in_bank 2", ib2, 0);
        chk("midfill rst ready 2", r2, 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("midfill rst no calc 2", cs2, 0);
        end
        rst = 1'b0;
        #1;
        chk("midfill release ready 2", r2, 1);
        do_frame(12'd12, 12, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
